// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 constants, schedule FSM state type and the
//               rotate / small-sigma helper functions used by the message
//               schedule generator and its expansion datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int SHA_WORD_W      = 32;
    localparam int SHA_ROUNDS      = 64;
    localparam int SHA_BLOCK_WORDS = 16;

    // Schedule FSM: LOAD collects the 16 message words, RUN emits W[0..63].
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    function automatic logic [SHA_WORD_W-1:0] rotr(
        input logic [SHA_WORD_W-1:0] x,
        input int unsigned           n
    );
        return (x >> n) | (x << (SHA_WORD_W - n));
    endfunction

    function automatic logic [SHA_WORD_W-1:0] small_sigma0(
        input logic [SHA_WORD_W-1:0] x
    );
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [SHA_WORD_W-1:0] small_sigma1(
        input logic [SHA_WORD_W-1:0] x
    );
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_w_expand.sv
`default_nettype none
// ============================================================================
// Module      : sha256_w_expand
// Description : Combinational SHA-256 schedule expansion
//               W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32.
// Ports       : i_w_tm2, i_w_tm7, i_w_tm15, i_w_tm16 - previous schedule words
//               o_w_t                                  - new schedule word
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_w_expand
    import sha256_pkg::*;
(
    input  logic [SHA_WORD_W-1:0] i_w_tm2,
    input  logic [SHA_WORD_W-1:0] i_w_tm7,
    input  logic [SHA_WORD_W-1:0] i_w_tm15,
    input  logic [SHA_WORD_W-1:0] i_w_tm16,
    output logic [SHA_WORD_W-1:0] o_w_t
);

    logic [SHA_WORD_W-1:0] w_s0;
    logic [SHA_WORD_W-1:0] w_s1;

    assign w_s0  = small_sigma0(i_w_tm15);
    assign w_s1  = small_sigma1(i_w_tm2);
    // Additions wrap naturally at the word width (mod 2^32).
    assign o_w_t = w_s1 + i_w_tm7 + w_s0 + i_w_tm16;

endmodule
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_schedule
// Description : SHA-256 message-schedule generator. Loads one 512-bit block
//               as 16 serial words into a 16-entry circular buffer, then
//               emits W[0..63] with their round index under valid/ready.
// Ports       : clk, rst_n (sync, active-low)
//               blk_valid / blk_ready / blk_word : message word input
//               w_valid / w_ready / w_out        : schedule word output
//               round_idx, w_last                : round t and t==63 flag
// Options     : SHA256_SCHED_OUTREG_EN - adds a one-entry output register
//               that cuts the sigma adder path from downstream logic.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int WORD_W = SHA_WORD_W,
    parameter int ROUNDS = SHA_ROUNDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [WORD_W-1:0] blk_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_out,
    output logic [5:0]        round_idx,
    output logic              w_last
);

    localparam logic [5:0] c_T_LAST   = 6'(ROUNDS - 1);
    localparam logic [3:0] c_LOAD_END = 4'(SHA_BLOCK_WORDS - 1);

    sched_state_t      r_state;
    logic [3:0]        r_load_cnt;
    logic [5:0]        r_t;
    logic [WORD_W-1:0] r_buf [SHA_BLOCK_WORDS];

    logic              w_in_load;
    logic              w_in_run;
    logic              w_beat;
    logic              w_core_valid;
    logic              w_core_ready;
    logic              w_core_fire;
    logic              w_core_last;
    logic              w_expanding;
    logic [3:0]        w_idx;
    logic [3:0]        w_idx_m2;
    logic [3:0]        w_idx_m7;
    logic [3:0]        w_idx_m15;
    logic [WORD_W-1:0] w_expand;
    logic [WORD_W-1:0] w_core_word;
    logic              w_buf_we;
    logic [3:0]        w_buf_waddr;
    logic [WORD_W-1:0] w_buf_wdata;

    assign w_in_load = (r_state == ST_LOAD);
    assign w_in_run  = (r_state == ST_RUN);

    // Gated with rst_n so the input side reads not-ready while held in reset.
    assign blk_ready = rst_n && w_in_load;
    assign w_beat    = blk_valid && w_in_load;

    // Circular buffer addressing: t-16 aliases t in a 16-entry ring.
    assign w_idx       = r_t[3:0];
    assign w_idx_m2    = r_t[3:0] - 4'd2;
    assign w_idx_m7    = r_t[3:0] - 4'd7;
    assign w_idx_m15   = r_t[3:0] - 4'd15;
    assign w_expanding = (r_t[5:4] != 2'b00);

    sha256_w_expand u_expand (
        .i_w_tm2  (r_buf[w_idx_m2]),
        .i_w_tm7  (r_buf[w_idx_m7]),
        .i_w_tm15 (r_buf[w_idx_m15]),
        .i_w_tm16 (r_buf[w_idx]),
        .o_w_t    (w_expand)
    );

    // Forced to zero outside RUN so stale buffer contents never reach w_out.
    assign w_core_word  = !w_in_run    ? '0 :
                          w_expanding  ? w_expand : r_buf[w_idx];
    assign w_core_valid = w_in_run;
    assign w_core_last  = w_in_run && (r_t == c_T_LAST);
    assign w_core_fire  = w_core_valid && w_core_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_load_cnt <= '0;
            r_t        <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (blk_valid) begin
                        // 4-bit counter wraps to 0 on the 16th beat.
                        r_load_cnt <= r_load_cnt + 4'd1;
                        if (r_load_cnt == c_LOAD_END) begin
                            r_state <= ST_RUN;
                            r_t     <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_core_fire) begin
                        if (w_core_last) begin
                            r_state <= ST_LOAD;
                            r_t     <= '0;
                        end else begin
                            r_t <= r_t + 6'd1;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Buffer write port: message words during LOAD, expanded words in RUN
    // (W[t] replaces W[t-16], which is no longer needed).
    assign w_buf_we    = rst_n && (w_beat || (w_core_fire && w_expanding));
    assign w_buf_waddr = w_in_load ? r_load_cnt : w_idx;
    assign w_buf_wdata = w_in_load ? blk_word   : w_expand;

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[w_buf_waddr] <= w_buf_wdata;
        end
    end

`ifdef SHA256_SCHED_OUTREG_EN
    logic              r_w_valid;
    logic              r_w_last;
    logic [WORD_W-1:0] r_w_out;
    logic [5:0]        r_round_idx;

    // Skid-free single entry: refill whenever empty or being drained.
    assign w_core_ready = !r_w_valid || w_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_valid   <= 1'b0;
            r_w_last    <= 1'b0;
            r_w_out     <= '0;
            r_round_idx <= '0;
        end else if (w_core_ready) begin
            r_w_valid   <= w_core_valid;
            r_w_last    <= w_core_last;
            r_w_out     <= w_core_word;
            r_round_idx <= r_t;
        end
    end

    assign w_valid   = r_w_valid;
    assign w_out     = r_w_out;
    assign round_idx = r_round_idx;
    assign w_last    = r_w_last;
`else
    assign w_core_ready = w_ready;
    assign w_valid      = w_core_valid;
    assign w_out        = w_core_word;
    assign round_idx    = r_t;
    assign w_last       = w_core_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_schedule
// Description : Self-checking bench for sha256_msg_schedule. The stimulus
//               process pushes the expected W sequence of every block into a
//               scoreboard queue; a monitor pops and compares on each output
//               handshake and checks stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_schedule;

    typedef logic [31:0] blk_t  [16];
    typedef logic [31:0] wtab_t [64];
    typedef struct {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blk_valid = 1'b0;
    logic        blk_ready;
    logic [31:0] blk_word = '0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_out;
    logic [5:0]  round_idx;
    logic        w_last;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   bp_en    = 1'b0;
    exp_t sb[$];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_word  (blk_word),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .round_idx (round_idx),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: actual=%08h required=%08h", name, act, req);
        end
    endtask

    // ---- reference model: plain 64-entry schedule array -------------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic wtab_t model(input blk_t m);
        wtab_t w;
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        return w;
    endfunction

    function automatic blk_t abc_block();
        blk_t m;
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m[0]  = 32'h61626380;
        m[15] = 32'h00000018;
        return m;
    endfunction

    function automatic blk_t rand_block();
        blk_t m;
        for (int i = 0; i < 16; i++) m[i] = $urandom();
        return m;
    endfunction

    task automatic push_expected(input wtab_t w);
        for (int k = 0; k < 64; k++) begin
            exp_t e;
            e.w    = w[k];
            e.idx  = 6'(k);
            e.last = (k == 63);
            sb.push_back(e);
        end
    endtask

    // Load one block; beats count only when blk_ready is seen high.
    task automatic send_block(input blk_t m, input bit gaps);
        int  i = 0;
        bit  acc;
        while (i < 16) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                blk_valid = 1'b0;
            end else begin
                blk_valid = 1'b1;
                blk_word  = m[i];
            end
            acc = blk_valid && blk_ready;
`ifndef SHA256_SCHED_OUTREG_EN
            if (acc && i == 15) check(!w_valid, "valid_before_last_beat", 32'(w_valid), 32'h0);
`endif
            @(posedge clk); #1;
            if (acc) i++;
        end
        blk_valid = 1'b0;
`ifdef SHA256_SCHED_OUTREG_EN
        check(!w_valid, "first_valid_early", 32'(w_valid), 32'h0);
        @(posedge clk); #1;
`else
        check(!blk_ready, "blk_ready_in_run", 32'(blk_ready), 32'h0);
`endif
        check(w_valid, "first_valid_latency", 32'(w_valid), 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check(sb.size() == 0, "drain_timeout", 32'(sb.size()), 32'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---- backpressure driver ---------------------------------------------
    initial begin
        forever begin
            @(posedge clk); #1;
            w_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ---- monitor / scoreboard --------------------------------------------
    initial begin
        bit          stalled   = 1'b0;
        bit          last_seen = 1'b0;
        logic [31:0] hold_w    = '0;
        logic [5:0]  hold_i    = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (stalled) begin
                check(w_valid, "stall_valid_hold", 32'(w_valid), 32'h1);
                check(w_out == hold_w, "stall_w_hold", w_out, hold_w);
                check(round_idx == hold_i, "stall_idx_hold", 32'(round_idx), 32'(hold_i));
            end
            if (last_seen) begin
                check(blk_ready, "blk_ready_after_last", 32'(blk_ready), 32'h1);
                check(!w_valid, "valid_after_last", 32'(w_valid), 32'h0);
                last_seen = 1'b0;
            end
`ifndef SHA256_SCHED_OUTREG_EN
            if (w_valid) check(!blk_ready, "blk_ready_during_run", 32'(blk_ready), 32'h0);
`endif
            if (rst_n && w_valid && w_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_word", w_out, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check(w_out == e.w, "w_out", w_out, e.w);
                    check(round_idx == e.idx, "round_idx", 32'(round_idx), 32'(e.idx));
                    check(w_last == e.last, "w_last", 32'(w_last), 32'(e.last));
                    if (w_last) last_seen = 1'b1;
                end
            end
            stalled = rst_n && w_valid && !w_ready;
            hold_w  = w_out;
            hold_i  = round_idx;
        end
    end

    // ---- stimulus --------------------------------------------------------
    initial begin
        wtab_t w;
        blk_t  m;
        blk_t  m2;
        int    n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check(!w_valid, "reset_w_valid", 32'(w_valid), 32'h0);
        check(!blk_ready, "reset_blk_ready", 32'(blk_ready), 32'h0);
        check(w_out == 32'h0, "reset_w_out", w_out, 32'h0);
        check(round_idx == 6'd0, "reset_round_idx", 32'(round_idx), 32'h0);
        check(!w_last, "reset_w_last", 32'(w_last), 32'h0);
        rst_n = 1'b1;
        #1;
        check(blk_ready, "blk_ready_after_reset", 32'(blk_ready), 32'h1);

        // "abc" block with hand-computed anchors
        m = abc_block();
        w = model(m);
        w[0]  = 32'h61626380;
        w[15] = 32'h00000018;
        w[16] = 32'h61626380;
        w[17] = 32'h000F0000;
        push_expected(w);
        send_block(m, 1'b0);
        drain();

        // Random block with input gaps
        m = rand_block();
        push_expected(model(m));
        send_block(m, 1'b1);
        drain();

        // "abc" again under random backpressure
        m = abc_block();
        w = model(m);
        w[16] = 32'h61626380;
        w[17] = 32'h000F0000;
        push_expected(w);
        bp_en = 1'b1;
        send_block(m, 1'b0);
        drain();
        bp_en = 1'b0;

        // Two back-to-back random blocks; second one waits out the first RUN
        m  = rand_block();
        m2 = rand_block();
        push_expected(model(m));
        send_block(m, 1'b0);
        push_expected(model(m2));
        send_block(m2, 1'b1);
        drain();

        // Reset while round 30 is on the output
        m = abc_block();
        push_expected(model(m));
        send_block(m, 1'b0);
        n = 0;
        while (sb.size() > 34 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(sb.size() == 34, "reset_point_reached", 32'(sb.size()), 32'd34);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check(!w_valid, "midrun_reset_w_valid", 32'(w_valid), 32'h0);
        check(round_idx == 6'd0, "midrun_reset_idx", 32'(round_idx), 32'h0);
        sb.delete();
        rst_n = 1'b1;
        #1;
        check(blk_ready, "midrun_reset_blk_ready", 32'(blk_ready), 32'h1);
        check(!w_valid, "midrun_after_w_valid", 32'(w_valid), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check(!w_valid, "no_stale_words", 32'(w_valid), 32'h0);

        // Fresh "abc" block after reset
        push_expected(model(m));
        send_block(m, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
